fix_tx_arbiter: RTL and testbench

//   Shares the single byte-wide outbound FIFO port (message_o/fifo_write_o/end_o) of the FIX engine

---
 rtl/fix_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fix_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_tx_arbiter.sv
// fix_tx_arbiter: message-atomic round-robin arbiter sharing the byte-wide TX FIFO port between sources.
// Optional feature macro FIX_ARB_ADMIN_PRIO_EN: source 0 (session admin) always wins arbitration in IDLE.
module fix_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int MAX_LEN = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [8*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  logic [NUM_SRC-1:0]   src_end_i,
  output logic [NUM_SRC-1:0]   src_ready_o,
  input  logic                 fifo_full_i,
  output logic                 fifo_write_o,
  output logic [7:0]           message_o,
  output logic                 end_o,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 len_err_o
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(MAX_LEN - 1);
  localparam logic [PW:0]   NUM_SRC_W = (PW + 1)'(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [PW-1:0]        rr_ptr_r, rr_ptr_s;
  logic [PW-1:0]        gidx_r, gidx_s;
  logic [NUM_SRC-1:0]   grant_r, grant_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic                 wr_r, wr_s;
  logic [7:0]           msg_r, msg_s;
  logic                 end_r, end_s;
  logic                 err_r, err_s;

  logic [NUM_SRC-1:0]   rot_s;
  logic [PW-1:0]        off_s;
  logic [PW:0]          sum_s;
  logic [PW-1:0]        pick_s;
  logic [NUM_SRC-1:0]   pick_oh_s;
  logic [PW-1:0]        rel_rr_s;
  logic [7:0]           sel_byte_s;
  logic                 sel_end_s;
  logic                 accept_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (idx == PW'(NUM_SRC - 1)) begin
      wrap_inc = {PW{1'b0}};
    end else begin
      wrap_inc = idx + PW'(1);
    end
  endfunction

  // Arbitration: rotate requests so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_s = NUM_SRC'({req_i, req_i} >> rr_ptr_r);
    off_s = {PW{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? PW'(i) : off_s;
    end
    sum_s  = {1'b0, off_s} + {1'b0, rr_ptr_r};
    pick_s = (sum_s >= NUM_SRC_W) ? PW'(sum_s - NUM_SRC_W) : sum_s[PW-1:0];
`ifdef FIX_ARB_ADMIN_PRIO_EN
    pick_s = req_i[0] ? {PW{1'b0}} : pick_s;
`endif
    pick_oh_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_s;
  end

  // Pointer value used when the current owner releases the port.
  always_comb begin
`ifdef FIX_ARB_ADMIN_PRIO_EN
    rel_rr_s = (gidx_r == {PW{1'b0}}) ? rr_ptr_r : wrap_inc(gidx_r);
`else
    rel_rr_s = wrap_inc(gidx_r);
`endif
  end

  // Byte/end mux from the granted source.
  always_comb begin
    sel_byte_s = 8'h00;
    sel_end_s  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_byte_s = (gidx_r == PW'(i)) ? src_data_i[8*i +: 8] : sel_byte_s;
      sel_end_s  = (gidx_r == PW'(i)) ? src_end_i[i] : sel_end_s;
    end
  end

  // Ready: stalled by FIFO almost-full while transferring, unconditional while flushing.
  always_comb begin
    case (state_r)
      XFER:    src_ready_o = grant_r & {NUM_SRC{~fifo_full_i}};
      FLUSH:   src_ready_o = grant_r;
      default: src_ready_o = {NUM_SRC{1'b0}};
    endcase
  end

  assign accept_s = |(src_valid_i & src_ready_o);

  // FSM next state and registered-output next values.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    gidx_s   = gidx_r;
    grant_s  = grant_r;
    cnt_s    = cnt_r;
    wr_s     = 1'b0;
    msg_s    = msg_r;
    end_s    = end_r;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_i) begin
          state_s = XFER;
          grant_s = pick_oh_s;
          gidx_s  = pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (accept_s) begin
          wr_s  = 1'b1;
          msg_s = sel_byte_s;
          if (sel_end_s) begin
            end_s    = 1'b1;
            state_s  = IDLE;
            grant_s  = {NUM_SRC{1'b0}};
            rr_ptr_s = rel_rr_s;
            cnt_s    = {CW{1'b0}};
          end else if (cnt_r == LAST_CNT) begin
            // Runaway source: terminate the message here and swallow the rest.
            end_s   = 1'b1;
            err_s   = 1'b1;
            state_s = FLUSH;
            cnt_s   = {CW{1'b0}};
          end else begin
            end_s = 1'b0;
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = XFER;
        end
      end
      FLUSH: begin
        if (accept_s && sel_end_s) begin
          state_s  = IDLE;
          grant_s  = {NUM_SRC{1'b0}};
          rr_ptr_s = rel_rr_s;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {NUM_SRC{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= {PW{1'b0}};
      gidx_r   <= {PW{1'b0}};
      grant_r  <= {NUM_SRC{1'b0}};
      cnt_r    <= {CW{1'b0}};
      wr_r     <= 1'b0;
      msg_r    <= 8'h00;
      end_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      gidx_r   <= gidx_s;
      grant_r  <= grant_s;
      cnt_r    <= cnt_s;
      wr_r     <= wr_s;
      msg_r    <= msg_s;
      end_r    <= end_s;
      err_r    <= err_s;
    end
  end

  assign fifo_write_o = wr_r;
  assign message_o    = msg_r;
  assign end_o        = end_r;
  assign grant_o      = grant_r;
  assign len_err_o    = err_r;
  assign busy_o       = (state_r != IDLE);

endmodule

// File: tb/tb_fix_tx_arbiter.sv
// Self-checking bench for fix_tx_arbiter (NUM_SRC=4, MAX_LEN=8): vector table plus hand-written sequences.
module tb_fix_tx_arbiter;
  localparam int NS = 4;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] req_i, src_valid_i, src_end_i, src_ready_o, grant_o;
  logic [8*NS-1:0] src_data_i;
  logic          fifo_full_i, fifo_write_o, end_o, busy_o, len_err_o;
  logic [7:0]    message_o;

  fix_tx_arbiter #(.NUM_SRC(NS), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .src_data_i(src_data_i),
    .src_valid_i(src_valid_i), .src_end_i(src_end_i), .src_ready_o(src_ready_o),
    .fifo_full_i(fifo_full_i), .fifo_write_o(fifo_write_o), .message_o(message_o),
    .end_o(end_o), .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // source byte stores: {end, byte}
  logic [8:0] smem [NS][64];
  int shead [NS];
  int stail [NS];
  int mcnt [NS];
  bit mflush [NS];
  logic [9:0] exp_q [$];       // {len_err, end, byte}
  logic [NS-1:0] gnt_log [$];
  int gap_log [$];
  int zero_run = 0;
  logic [NS-1:0] prev_gnt = '0;
  int nwrites, nerrs, cyc;
  int full_from = 1000;
  int full_len = 0;
  bit exp_wr;

  typedef struct {
    int src; int len; logic [7:0] base; int ffrom; int flen; int ewr; int eerr;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int s = 0; s < NS; s++) if (shead[s] != stail[s]) p = 1;
    return p;
  endfunction

  function automatic bit any_flush();
    bit f = 0;
    for (int s = 0; s < NS; s++) if (mflush[s]) f = 1;
    return f;
  endfunction

  task automatic load_msg(input int s, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      smem[s][stail[s] % 64] = {(k == len - 1), 8'(base + k)};
      stail[s]++;
    end
  endtask

  task automatic drive_inputs();
    logic [NS-1:0] rq, en;
    logic [8*NS-1:0] dt;
    logic [8:0] h;
    rq = '0; en = '0; dt = '0;
    for (int s = 0; s < NS; s++) begin
      if (shead[s] != stail[s]) begin
        h = smem[s][shead[s] % 64];
        rq[s] = 1'b1;
        en[s] = h[8];
        dt[8*s +: 8] = h[7:0];
      end
    end
    req_i = rq;
    src_valid_i = rq;
    src_end_i = en;
    src_data_i = dt;
    fifo_full_i = (cyc >= full_from) && (cyc < full_from + full_len);
  endtask

  // scoreboard model: length limit, forced end and flush tracked per source
  task automatic model_accept(input int s);
    logic [8:0] b;
    b = smem[s][shead[s] % 64];
    if (mflush[s]) begin
      if (b[8]) mflush[s] = 0;
    end else begin
      mcnt[s]++;
      exp_wr = 1;
      if (b[8]) begin
        exp_q.push_back({2'b01, b[7:0]});
        mcnt[s] = 0;
      end else if (mcnt[s] == ML) begin
        exp_q.push_back({2'b11, b[7:0]});
        mcnt[s] = 0;
        mflush[s] = 1;
      end else begin
        exp_q.push_back({2'b00, b[7:0]});
      end
    end
    shead[s]++;
  endtask

  task automatic sample();
    logic [9:0] e;
    if (exp_wr) begin
      chk("write", fifo_write_o, 1);
      e = exp_q.pop_front();
      chk("byte", message_o, e[7:0]);
      chk("end", end_o, e[8]);
      chk("len_err", len_err_o, e[9]);
    end else begin
      chk("no_write", fifo_write_o, 0);
      chk("no_len_err", len_err_o, 0);
    end
    if (fifo_write_o) nwrites++;
    if (len_err_o) nerrs++;
    chk("grant_onehot", $onehot0(grant_o), 1);
    if (grant_o != '0 && prev_gnt == '0) begin
      gnt_log.push_back(grant_o);
      gap_log.push_back(zero_run);
    end
    zero_run = (grant_o == '0) ? zero_run + 1 : 0;
    prev_gnt = grant_o;
  endtask

  task automatic step();
    logic [NS-1:0] acc;
    @(negedge clk);
    cyc++;
    drive_inputs();
    #1;
    acc = src_valid_i & src_ready_o;
    chk("ready_subset", src_ready_o & ~grant_o, 0);
    if (fifo_full_i && busy_o && !any_flush()) chk("ready_stall", src_ready_o, 0);
    if (busy_o && any_flush()) chk("ready_flush", src_ready_o, grant_o);
    exp_wr = 0;
    for (int s = 0; s < NS; s++) if (acc[s]) model_accept(s);
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic run_idle(input int budget, input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while ((pending() || busy_o) && n < budget);
    chk({nm, "_timeout"}, (n < budget), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_grant"}, grant_o, 0);
    chk({nm, "_write"}, fifo_write_o, 0);
    chk({nm, "_msg"}, message_o, 0);
    chk({nm, "_end"}, end_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_lenerr"}, len_err_o, 0);
  endtask

  task automatic do_reset();
    for (int s = 0; s < NS; s++) begin
      shead[s] = stail[s];
      mcnt[s] = 0;
      mflush[s] = 0;
    end
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [NS-1:0] exp_order [5];

  initial begin
    rst = 1'b1;
    fifo_full_i = 1'b0;
    req_i = '0; src_valid_i = '0; src_end_i = '0; src_data_i = '0;
    cyc = 0;
    for (int s = 0; s < NS; s++) begin
      shead[s] = 0; stail[s] = 0; mcnt[s] = 0; mflush[s] = 0;
    end
    do_reset();
    check_reset_outputs("reset");

    // contention from reset: src0 carries two messages
    load_msg(0, 2, 8'h00); load_msg(0, 2, 8'h08);
    load_msg(1, 2, 8'h10); load_msg(2, 2, 8'h20); load_msg(3, 2, 8'h30);
    gnt_log.delete(); gap_log.delete();
    run_idle(100, "contend");
`ifdef FIX_ARB_ADMIN_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    chk("contend_ngrants", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gnt_log.size()) chk("contend_order", gnt_log[i], exp_order[i]);
      if (i > 0 && i < gap_log.size()) chk("contend_gap", gap_log[i], 1);
    end

    // table-driven single-source vectors
    vecs[0] = '{0, 5,  8'h38, 1000, 0, 5, 0};
    vecs[1] = '{1, 6,  8'h10, 3,    4, 6, 0};
    vecs[2] = '{2, 12, 8'h50, 10,   3, 8, 1};
    vecs[3] = '{3, 8,  8'h60, 1000, 0, 8, 0};
    vecs[4] = '{1, 1,  8'h77, 1000, 0, 1, 0};
    vecs[5] = '{2, 9,  8'h80, 4,    2, 8, 1};
    vecs[6] = '{0, 8,  8'hA0, 2,    8, 8, 0};
    for (int v = 0; v < 7; v++) begin
      cyc = 0;
      full_from = vecs[v].ffrom;
      full_len = vecs[v].flen;
      nwrites = 0; nerrs = 0;
      gnt_log.delete();
      load_msg(vecs[v].src, vecs[v].len, vecs[v].base);
      run_idle(60, "vec");
      chk("vec_writes", nwrites, vecs[v].ewr);
      chk("vec_lenerr", nerrs, vecs[v].eerr);
      chk("vec_ngrants", gnt_log.size(), 1);
      if (gnt_log.size() > 0) chk("vec_grant", gnt_log[0], 4'b0001 << vecs[v].src);
      chk("vec_grant_released", grant_o, 0);
    end
    full_from = 1000;
    full_len = 0;

    // reset in the middle of a transfer
    do_reset();
    load_msg(1, 2, 8'hB0);
    run_idle(20, "pre_rst");
    load_msg(2, 6, 8'hC0);
    load_msg(3, 2, 8'hD0);
    gnt_log.delete();
    begin
      int n = 0;
      while (mcnt[2] < 3 && n < 20) begin
        step();
        n++;
      end
      chk("midrst_timeout", (n < 20), 1);
    end
    if (gnt_log.size() > 0) chk("midrst_first_grant", gnt_log[0], 4'b0100);
    shead[2] = stail[2];
    mcnt[2] = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    exp_q.delete();
    load_msg(1, 2, 8'hE0);
    gnt_log.delete();
    run_idle(40, "post_rst");
    chk("post_rst_ngrants", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("post_rst_lowest", gnt_log[0], 4'b0010);

    // admin priority: rr_ptr=2, req_i=1101
    do_reset();
    load_msg(1, 1, 8'hF0);
    run_idle(20, "prio_pre");
    load_msg(0, 1, 8'hF1); load_msg(2, 1, 8'hF2); load_msg(3, 1, 8'hF3);
    gnt_log.delete();
    run_idle(40, "prio");
`ifdef FIX_ARB_ADMIN_PRIO_EN
    exp_order[0:2] = '{4'b0001, 4'b0100, 4'b1000};
`else
    exp_order[0:2] = '{4'b0100, 4'b1000, 4'b0001};
`endif
    chk("prio_ngrants", gnt_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < gnt_log.size()) chk("prio_order", gnt_log[i], exp_order[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
